// File: rtl/capture_control.sv
// capture_control: circular sample buffer with pre/post trigger capture and a
// valid/ready readout port that emits the stored window oldest-first.
module capture_control #(
  parameter int SAMPLE_WIDTH = 8,
  parameter int ADDR_WIDTH   = 10
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    arm,
  input  logic                    run,
  input  logic                    valid,
  input  logic [SAMPLE_WIDTH-1:0] dataIn,
  input  logic [ADDR_WIDTH-1:0]   post_count,
  input  logic                    out_ready,
  output logic                    out_valid,
  output logic [SAMPLE_WIDTH-1:0] out_data,
  output logic                    out_last,
  output logic                    armed,
  output logic                    triggered,
  output logic                    busy
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int CW    = ADDR_WIDTH + 1;

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);
  localparam logic [CW-1:0]         CNT_ONE  = CW'(1);
  localparam logic [CW-1:0]         CNT_FULL = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, ARMED, POST, READOUT} state_t;

  logic [SAMPLE_WIDTH-1:0] mem [DEPTH];

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   wrPtr_q, wrPtr_d;
  logic                    wrapped_q, wrapped_d;
  logic [ADDR_WIDTH-1:0]   postCnt_q, postCnt_d;
  logic [ADDR_WIDTH-1:0]   remain_q, remain_d;
  logic                    triggered_q, triggered_d;
  logic [ADDR_WIDTH-1:0]   rdAddr_q, rdAddr_d;
  logic [CW-1:0]           beatsLeft_q, beatsLeft_d;
  logic                    rdFirst_q, rdFirst_d;
  logic                    outValid_q, outValid_d;
  logic                    outLast_q, outLast_d;
  logic [SAMPLE_WIDTH-1:0] outData_q, outData_d;

  logic                    wrEn;
  logic [ADDR_WIDTH-1:0]   startAddr;
  logic [CW-1:0]           startCount;
  logic [ADDR_WIDTH-1:0]   loadAddr;
  logic [CW-1:0]           loadCnt;

  // Next-state logic: capture control, trigger bookkeeping and readout sequencing.
  // The first READOUT cycle derives the window from the final write pointer and
  // loads the first beat directly, so out_valid rises one cycle after entry.
  always_comb begin
    state_d     = state_q;
    wrPtr_d     = wrPtr_q;
    wrapped_d   = wrapped_q;
    postCnt_d   = postCnt_q;
    remain_d    = remain_q;
    triggered_d = triggered_q;
    rdAddr_d    = rdAddr_q;
    beatsLeft_d = beatsLeft_q;
    rdFirst_d   = rdFirst_q;
    outValid_d  = outValid_q;
    outLast_d   = outLast_q;
    outData_d   = outData_q;
    wrEn        = 1'b0;

    startAddr  = wrapped_q ? wrPtr_q : '0;
    startCount = wrapped_q ? CNT_FULL : {1'b0, wrPtr_q};
    loadAddr   = rdFirst_q ? startAddr : rdAddr_q;
    loadCnt    = rdFirst_q ? startCount : beatsLeft_q;

    if (arm) begin
      state_d     = ARMED;
      wrPtr_d     = '0;
      wrapped_d   = 1'b0;
      triggered_d = 1'b0;
      postCnt_d   = post_count;
      outValid_d  = 1'b0;
      outLast_d   = 1'b0;
      rdFirst_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
        end
        ARMED: begin
          if (run) begin
            triggered_d = 1'b1;
            if (postCnt_q == '0) begin
              state_d   = READOUT;
              rdFirst_d = 1'b1;
            end else if (valid) begin
              wrEn = 1'b1;
              if (postCnt_q == ADDR_ONE) begin
                state_d   = READOUT;
                rdFirst_d = 1'b1;
              end else begin
                state_d  = POST;
                remain_d = postCnt_q - ADDR_ONE;
              end
            end else begin
              state_d  = POST;
              remain_d = postCnt_q;
            end
          end else if (valid) begin
            wrEn = 1'b1;
          end
        end
        POST: begin
          if (valid) begin
            wrEn     = 1'b1;
            remain_d = remain_q - ADDR_ONE;
            if (remain_q == ADDR_ONE) begin
              state_d   = READOUT;
              rdFirst_d = 1'b1;
            end
          end
        end
        READOUT: begin
          rdFirst_d = 1'b0;
          if (rdFirst_q && startCount == '0) begin
            state_d = IDLE;
          end else if (outValid_q && out_ready && outLast_q) begin
            outValid_d = 1'b0;
            outLast_d  = 1'b0;
            state_d    = IDLE;
          end else if ((!outValid_q || out_ready) && loadCnt != '0) begin
            outData_d   = mem[loadAddr];
            outValid_d  = 1'b1;
            outLast_d   = (loadCnt == CNT_ONE);
            rdAddr_d    = loadAddr + ADDR_ONE;
            beatsLeft_d = loadCnt - CNT_ONE;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    if (wrEn) begin
      wrPtr_d = wrPtr_q + ADDR_ONE;
      if (&wrPtr_q) begin
        wrapped_d = 1'b1;
      end
    end
  end

  // Sample storage; contents are not reset, only the pointers that index them.
  always_ff @(posedge clock) begin
    if (wrEn) begin
      mem[wrPtr_q] <= dataIn;
    end
  end

  // Control and output registers with asynchronous reset to an idle, empty buffer.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      wrPtr_q     <= '0;
      wrapped_q   <= 1'b0;
      postCnt_q   <= '0;
      remain_q    <= '0;
      triggered_q <= 1'b0;
      rdAddr_q    <= '0;
      beatsLeft_q <= '0;
      rdFirst_q   <= 1'b0;
      outValid_q  <= 1'b0;
      outLast_q   <= 1'b0;
      outData_q   <= '0;
    end else begin
      state_q     <= state_d;
      wrPtr_q     <= wrPtr_d;
      wrapped_q   <= wrapped_d;
      postCnt_q   <= postCnt_d;
      remain_q    <= remain_d;
      triggered_q <= triggered_d;
      rdAddr_q    <= rdAddr_d;
      beatsLeft_q <= beatsLeft_d;
      rdFirst_q   <= rdFirst_d;
      outValid_q  <= outValid_d;
      outLast_q   <= outLast_d;
      outData_q   <= outData_d;
    end
  end

  assign out_valid = outValid_q;
  assign out_data  = outData_q;
  assign out_last  = outLast_q;
  assign armed     = (state_q == ARMED);
  assign triggered = triggered_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: doc/capture_control.md
CAPTURE_CONTROL -- requirements
Module: capture_control

Interface
REQ-001 SHALL have parameter SAMPLE_WIDTH, default 8: width of one sample.
REQ-002 SHALL have parameter ADDR_WIDTH, default 10: buffer depth DEPTH = 2**ADDR_WIDTH samples.
REQ-003 SHALL have port clock, input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port arm, input, 1 bit: one-cycle pulse that starts a new capture.
REQ-006 SHALL have port run, input, 1 bit: one-cycle trigger pulse from the trigger block.
REQ-007 SHALL have port valid, input, 1 bit: dataIn holds a sample this cycle.
REQ-008 SHALL have port dataIn, input, SAMPLE_WIDTH bits: sample data.
REQ-009 SHALL have port post_count, input, ADDR_WIDTH bits: number of samples to store after the trigger; latched on arm.
REQ-010 SHALL have port out_ready, input, 1 bit: downstream accepts out_data.
REQ-011 SHALL have port out_valid, output, 1 bit: out_data holds a readout sample.
REQ-012 SHALL have port out_data, output, SAMPLE_WIDTH bits: readout sample.
REQ-013 SHALL have port out_last, output, 1 bit: high with the final readout sample.
REQ-014 SHALL have port armed, output, 1 bit: high in state ARMED.
REQ-015 SHALL have port triggered, output, 1 bit: high from trigger acceptance until the next arm or reset.
REQ-016 SHALL have port busy, output, 1 bit: high in any state other than IDLE.

Function
REQ-017 SHALL contain a DEPTH x SAMPLE_WIDTH circular buffer with write pointer wr_ptr (ADDR_WIDTH bits) and a sticky wrapped flag.
REQ-018 SHALL implement states IDLE, ARMED, POST, READOUT.
REQ-019 On arm in any state: next state ARMED; wr_ptr=0; wrapped=0; triggered=0; post_count latched; out_valid=0; any readout in progress abandoned.
REQ-020 In ARMED and POST, each cycle with valid=1 SHALL write dataIn at wr_ptr and increment wr_ptr modulo DEPTH; wrapping from DEPTH-1 to 0 SHALL set wrapped.
REQ-021 In ARMED, run=1 SHALL set triggered; the same-cycle sample, if valid, counts as post-trigger sample 1.
REQ-022 After trigger, capture SHALL end when the latched post_count post-trigger samples have been written; the state is POST until then, and READOUT the cycle after the last write.
REQ-023 post_count=0: the trigger-cycle sample SHALL NOT be written; next state READOUT.
REQ-024 post_count=1 with a valid trigger-cycle sample: that sample written; next state READOUT.
REQ-025 run SHALL be ignored in IDLE, POST, READOUT; valid ignored in IDLE and READOUT.
REQ-026 READOUT SHALL emit oldest-first: if wrapped, DEPTH samples starting at wr_ptr; else wr_ptr samples starting at address 0.
REQ-027 Zero stored samples (not wrapped, wr_ptr=0): no output beats; READOUT -> IDLE next cycle.
REQ-028 Handshake: a beat transfers when out_valid and out_ready are both 1; out_data and out_last SHALL hold stable while out_valid=1 and out_ready=0.
REQ-029 First out_valid SHALL assert no later than 2 cycles after READOUT entry; with out_ready held 1, throughput SHALL be one beat per cycle.
REQ-030 After the out_last beat transfers: out_valid=0, state IDLE; triggered remains 1.
REQ-031 Read-address arithmetic SHALL be modulo DEPTH; beat counter SHALL be ADDR_WIDTH+1 bits so that DEPTH is representable.
REQ-032 arm and run in the same cycle: arm wins; run is ignored.

Reset
REQ-033 On reset=1, asynchronously: state IDLE, wr_ptr=0, wrapped=0, out_valid=0, out_last=0, out_data=0, armed=0, triggered=0, busy=0; buffer contents are undefined.
REQ-034 Reset asserted mid-capture or mid-readout SHALL abort it; no beat transfers after reset deasserts until a new arm.

Verification
REQ-035 DEPTH=16, arm with post_count=4; 5 valid samples 0x00..0x04; run with 0x05; valid 0x06..0x08 -> READOUT; 9 beats 0x00..0x08, out_last on 0x08.
REQ-036 DEPTH=16, post_count=2; 20 valid samples 0x00..0x13, run coincident with 0x12 -> wrapped; 16 beats 0x04..0x13; out_last on 0x13.
REQ-037 post_count=0, run coincident with 0x03 after 0x00..0x02 -> 3 beats 0x00..0x02; 0x03 not output.
REQ-038 During readout, hold out_ready=0 for 5 cycles -> out_data/out_last stable, no beat lost or repeated.
REQ-039 Reset in POST, then run pulses without arm -> busy=0, triggered=0, out_valid never asserts.
REQ-040 arm and run in the same cycle -> armed=1, triggered=0; a later run triggers normally.
